// File: rtl/nn_pkg.sv
// nn_pkg: shared definitions for the feed-forward NN block.
//   NN_WORD_W    - weight RAM word width in bits
//   NN_ADDR_W    - weight RAM address width
//   NN_NUM_WORDS - words in one complete weight image
//   NN_BYTE_W    - width of one element of the weight byte stream
//   loader_state_e - state encoding of the weight loader FSM
package nn_pkg;

  localparam int NN_WORD_W    = 256;
  localparam int NN_ADDR_W    = 4;
  localparam int NN_NUM_WORDS = 16;
  localparam int NN_BYTE_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } loader_state_e;

endpackage : nn_pkg

// File: rtl/nn_weight_loader.sv
// nn_weight_loader: packs a valid/ready byte stream into WORD_W-bit words and
// writes them, in address order, into the weight RAM. done rises once the
// RAM holds a complete image of NUM_WORDS words.
//
// Ports:
//   CLK        system clock, all registers on the rising edge
//   RST        synchronous active-high reset
//   start      one-cycle pulse, begins a load (only from IDLE or DONE)
//   in_valid   stream byte valid
//   in_byte    stream byte
//   in_ready   loader accepts a byte this cycle
//   mem_addr   RAM write address
//   mem_wdata  RAM write data (first stream byte in the LSBs)
//   mem_we     RAM write enable, one cycle per word
//   busy       load in progress (LOAD, WRITE, CHECK)
//   done       image complete, held until the next start or RST
//   err        checksum mismatch (tied 0 unless LOADER_CHECKSUM_EN)
//
// Build option: define LOADER_CHECKSUM_EN to append a checksum byte to the
// image. The loader keeps an XOR of all image bytes and compares it with one
// extra byte accepted after the final word is written.
module nn_weight_loader
  import nn_pkg::*;
#(
  parameter int WORD_W    = NN_WORD_W,
  parameter int BYTE_W    = NN_BYTE_W,
  parameter int ADDR_W    = NN_ADDR_W,
  parameter int NUM_WORDS = NN_NUM_WORDS
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_byte,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int BYTES = WORD_W / BYTE_W;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q, csum_d;
  logic              err_q, err_d;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d   = csum_q;
    err_d    = err_q;
`endif
    in_ready = 1'b0;
    mem_we   = 1'b0;
    busy     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          addr_d  = '0;
          cnt_d   = '0;
          wdata_d = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
          err_d   = 1'b0;
`endif
        end
      end

      ST_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          // Lane decode instead of a variable part-select keeps the
          // insert mux explicit: byte k lands in lane k.
          for (int k = 0; k < BYTES; k++) begin
            if (cnt_q == CNT_W'(k)) begin
              wdata_d[k*BYTE_W +: BYTE_W] = in_byte;
            end
          end
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_byte;
`endif
          if (cnt_q == LAST_BYTE) begin
            state_d = ST_WRITE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_WRITE: begin
        // Address and data registers are untouched here, so the RAM sees
        // a stable word for the whole write cycle.
        mem_we = 1'b1;
        busy   = 1'b1;
        if (addr_q == LAST_ADDR) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
`endif
        end else begin
          addr_d  = addr_q + 1'b1;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end
      end

`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          err_d   = (in_byte != csum_q);
          state_d = ST_DONE;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign done      = (state_q == ST_DONE);
`ifdef LOADER_CHECKSUM_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule : nn_weight_loader

// File: tb/tb_nn_weight_loader.sv
// tb_nn_weight_loader: directed bench for nn_weight_loader. Inputs are driven
// and outputs sampled 1ns after the rising edge; a negedge monitor records
// every RAM write into a model RAM for later comparison.
module tb_nn_weight_loader;
  import nn_pkg::*;

  localparam int WORD_W = NN_WORD_W;
  localparam int BYTE_W = NN_BYTE_W;
  localparam int ADDR_W = NN_ADDR_W;
  localparam int NWORDS = NN_NUM_WORDS;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [BYTE_W-1:0] in_byte = '0;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_we;
  logic              busy;
  logic              done;
  logic              err;

  nn_weight_loader dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_ready  (in_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc++;

  // Write monitor
  logic [WORD_W-1:0] ram [NWORDS];
  int wr_cnt, acc_cnt, bad_we, rdy_seen;
  int wr_addr[$];
  int wr_cyc[$];

  always @(negedge CLK) begin
    if (in_valid && in_ready) acc_cnt++;
    if (in_ready) rdy_seen++;
    if (mem_we) begin
      ram[mem_addr] = mem_wdata;
      if (acc_cnt != 32 * (wr_cnt + 1)) bad_we++;
      wr_cnt++;
      wr_addr.push_back(int'(mem_addr));
      wr_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [WORD_W-1:0] obs,
                     input logic [WORD_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_mon;
    wr_cnt = 0; acc_cnt = 0; bad_we = 0; rdy_seen = 0;
    wr_addr.delete();
    wr_cyc.delete();
    for (int w = 0; w < NWORDS; w++) ram[w] = '0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic send_one(input logic [BYTE_W-1:0] v);
    int t;
    in_valid = 1'b1;
    in_byte  = v;
    t = 0;
    while (!in_ready) begin
      tick;
      t++;
      if (t > 200) begin
        $display("FAIL in_ready_timeout observed=0 expected=1");
        $fatal(1, "in_ready never asserted");
      end
    end
    tick;
    in_valid = 1'b0;
  endtask

  task automatic send_range(input int first, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      send_one(8'((first + i) % 256));
      repeat (gap) tick;
    end
  endtask

  task automatic wait_done;
    int t;
    t = 0;
    while (!done) begin
      tick;
      t++;
      if (t > 200) begin
        $display("FAIL done_timeout observed=0 expected=1");
        $fatal(1, "done never asserted");
      end
    end
  endtask

  // Checksum byte for an image of i%256 bytes: 512 bytes = two full
  // 0..255 runs, whose XOR is 0.
  task automatic end_image;
`ifdef LOADER_CHECKSUM_EN
    send_one(8'h00);
`endif
  endtask

  task automatic check_image(input string tag);
    logic [WORD_W-1:0] e;
    chk({tag, "_wr_cnt"}, WORD_W'(wr_cnt), WORD_W'(NWORDS));
    for (int w = 0; w < NWORDS && w < wr_addr.size(); w++)
      chk($sformatf("%s_addr%0d", tag, w), WORD_W'(wr_addr[w]), WORD_W'(w));
    for (int w = 0; w < NWORDS; w++) begin
      for (int k = 0; k < 32; k++) e[k*8 +: 8] = 8'((32 * w + k) % 256);
      chk($sformatf("%s_word%0d", tag, w), ram[w], e);
    end
    chk({tag, "_bad_we"}, WORD_W'(bad_we), '0);
  endtask

  initial begin
    clear_mon;

    // Reset / idle
    RST = 1'b1;
    tick; tick;
    chk("rst_in_ready", WORD_W'(in_ready), '0);
    chk("rst_mem_we",   WORD_W'(mem_we),   '0);
    chk("rst_mem_addr", WORD_W'(mem_addr), '0);
    chk("rst_wdata",    mem_wdata,         '0);
    chk("rst_busy",     WORD_W'(busy),     '0);
    chk("rst_done",     WORD_W'(done),     '0);
    chk("rst_err",      WORD_W'(err),      '0);
    RST = 1'b0;

    clear_mon;
    in_valid = 1'b1;
    in_byte  = 8'h55;
    repeat (10) tick;
    in_valid = 1'b0;
    chk("idle_ready_seen", WORD_W'(rdy_seen), '0);
    chk("idle_we_seen",    WORD_W'(wr_cnt),   '0);
    chk("idle_busy",       WORD_W'(busy),     '0);

    // Full load, continuous valid
    clear_mon;
    pulse_start;
    chk("load_busy",  WORD_W'(busy),     WORD_W'(1));
    chk("load_ready", WORD_W'(in_ready), WORD_W'(1));
    chk("load_addr0", WORD_W'(mem_addr), '0);
    send_range(0, 512, 0);
`ifndef LOADER_CHECKSUM_EN
    chk("last_we",        WORD_W'(mem_we),   WORD_W'(1));
    chk("last_addr",      WORD_W'(mem_addr), WORD_W'(15));
    chk("last_done_low",  WORD_W'(done),     '0);
    tick;
    chk("done_high",      WORD_W'(done),     WORD_W'(1));
    chk("done_busy",      WORD_W'(busy),     '0);
    chk("done_we",        WORD_W'(mem_we),   '0);
    chk("done_ready",     WORD_W'(in_ready), '0);
`else
    end_image;
    wait_done;
`endif
    chk("full_err", WORD_W'(err), '0);
    check_image("full");
    chk("word0_literal", ram[0],
        256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100);
    for (int i = 1; i < NWORDS && i < wr_cyc.size(); i++)
      chk($sformatf("spacing%0d", i), WORD_W'(wr_cyc[i] - wr_cyc[i-1]), WORD_W'(33));

    // Restart from DONE, then backpressure gaps
    clear_mon;
    pulse_start;
    chk("restart_done", WORD_W'(done),     '0);
    chk("restart_busy", WORD_W'(busy),     WORD_W'(1));
    chk("restart_addr", WORD_W'(mem_addr), '0);
    send_range(0, 512, 1);
    end_image;
    wait_done;
    check_image("gaps");

    // Reset mid-load
    clear_mon;
    pulse_start;
    send_range(0, 40, 0);
    RST = 1'b1;
    tick;
    chk("midrst_busy",  WORD_W'(busy),     '0);
    chk("midrst_ready", WORD_W'(in_ready), '0);
    chk("midrst_addr",  WORD_W'(mem_addr), '0);
    chk("midrst_wdata", mem_wdata,         '0);
    RST = 1'b0;
    tick;
    chk("midrst_wr_cnt", WORD_W'(wr_cnt), WORD_W'(1));
    chk("midrst_we_idle", WORD_W'(mem_we), '0);
    if (wr_addr.size() > 0) chk("midrst_wr_addr", WORD_W'(wr_addr[0]), '0);
    clear_mon;
    pulse_start;
    send_range(0, 512, 0);
    end_image;
    wait_done;
    check_image("after_rst");

    // start while busy is ignored
    clear_mon;
    pulse_start;
    send_range(0, 100, 0);
    pulse_start;
    chk("busy_start_busy", WORD_W'(busy),     WORD_W'(1));
    chk("busy_start_addr", WORD_W'(mem_addr), WORD_W'(3));
    chk("busy_start_wrs",  WORD_W'(wr_cnt),   WORD_W'(3));
    send_range(100, 412, 0);
    end_image;
    wait_done;
    check_image("busy_start");

`ifdef LOADER_CHECKSUM_EN
    // Checksum: 512 x 0xA5 XORs to 0x00
    clear_mon;
    pulse_start;
    for (int i = 0; i < 512; i++) send_one(8'hA5);
    send_one(8'h00);
    wait_done;
    chk("csum_ok_err",  WORD_W'(err),  '0);
    chk("csum_ok_done", WORD_W'(done), WORD_W'(1));
    pulse_start;
    for (int i = 0; i < 512; i++) send_one(8'hA5);
    send_one(8'h01);
    wait_done;
    chk("csum_bad_err",  WORD_W'(err),  WORD_W'(1));
    chk("csum_bad_done", WORD_W'(done), WORD_W'(1));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_nn_weight_loader

// File: doc/nn_weight_loader.md
Name: nn_weight_loader

Overview:
- Upstream stage of the feed-forward NN block. Receives a byte stream of weights over a valid/ready handshake.
- Packs each group of 32 bytes into one 256-bit word and writes the word into the 16-entry x 256-bit weight RAM through its address, write-data and write-enable ports.
- Signals `done` when the RAM holds a complete weight image, so the NN controller can start reading.

Parameters:
- WORD_W, 256, RAM word width in bits; must be a multiple of BYTE_W.
- BYTE_W, 8, width of one stream element.
- ADDR_W, 4, RAM address width.
- NUM_WORDS, 16, words per image; 1..2**ADDR_W.

Ports:
- CLK  in  1  system clock; every register updates on the rising edge.
- RST  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- in_valid  in  1  stream byte valid.
- in_byte  in  BYTE_W  stream byte.
- in_ready  out  1  loader can accept a byte.
- mem_addr  out  ADDR_W  RAM write address.
- mem_wdata  out  WORD_W  RAM write data.
- mem_we  out  1  RAM write enable.
- busy  out  1  a load is in progress.
- done  out  1  image complete; held until the next start or RST.
- err  out  1  checksum mismatch; only driven when LOADER_CHECKSUM_EN is defined, otherwise tied 0.

Behaviour:
- Reset values: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, byte counter=0.
- RST applied mid-load aborts the load: no partial word is written and the next cycle is IDLE.
- FSM transitions:
  - IDLE: start -> LOAD, with mem_addr=0, byte_cnt=0, done=0, err=0.
  - LOAD: in_ready=1. A byte is accepted at an edge where in_valid&&in_ready. Byte k of a word goes to mem_wdata[BYTE_W*k +: BYTE_W] (little-endian, first byte in the LSBs). byte_cnt counts 0..WORD_W/BYTE_W-1. Accepting the last byte of a word -> WRITE.
  - WRITE: in_ready=0, mem_we=1 for exactly one cycle. mem_addr and mem_wdata are stable during that cycle.
    - If mem_addr==NUM_WORDS-1: -> DONE, or -> CHECK when the feature is enabled.
    - Otherwise: mem_addr+1, byte_cnt=0, -> LOAD.
  - DONE: done=1, busy=0, in_ready=0. start -> LOAD, which clears done and restarts at address 0.
- busy=1 in LOAD, WRITE and CHECK.
- start is ignored while busy.
- in_valid outside LOAD is ignored, and the byte is not consumed.
- Latency:
  - Last byte of a word accepted at edge N: mem_we=1 during cycle N..N+1, and the RAM captures the word at edge N+1.
  - Final word written at edge N+1: done=1 from edge N+1 (no checksum).
- Stalls: gaps in in_valid simply hold the state. There is no timeout.
- mem_addr never wraps within an image. Its maximum value is NUM_WORDS-1.
- Bubble rate: one bubble cycle per word (WRITE), so peak throughput is 32 bytes per 33 cycles.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- When defined:
  - A running 8-bit XOR of all accepted image bytes is kept.
  - After the final WRITE the FSM enters CHECK with in_ready=1 and accepts one extra byte.
  - err=1 if that byte differs from the running XOR; then -> DONE.
  - done asserts even on error. err is held until the next start or RST.
- When undefined: there is no CHECK state, err is tied 0, and there is no extra byte.

Decomposition:
- Shared package nn_pkg:
  - NN_WORD_W=256, NN_ADDR_W=4, NN_NUM_WORDS=16, NN_BYTE_W=8.
  - Loader state enum (IDLE, LOAD, WRITE, CHECK, DONE).
- Parameters default from the package.
- No sub-module required.
- Optional sub-module nn_byte_packer: shift/insert register plus byte counter with a word_full flag; the FSM stays in nn_weight_loader.

Test Plan:
- Reset/idle: RST high for 2 cycles -> all outputs 0. start=0 with in_valid=1 for 10 cycles -> in_ready=0 and mem_we never asserts.
- Full load, continuous valid: 512 bytes of value i%256 -> 16 mem_we pulses at addr 0..15, each 33 cycles apart. Word 0 = bytes 0x1F..0x00 MSB-to-LSB. done=1 one edge after the last write.
- Backpressure gaps: valid toggling every other cycle -> identical RAM contents. mem_we only follows the 32nd accepted byte.
- Reset mid-load: RST after 40 bytes -> exactly one write (addr 0). No write at addr 1. Then start plus 512 bytes -> full image written from addr 0.
- start while busy: pulse start at byte 100 -> ignored, mem_addr continues 3,4,... Pulse start while done -> done drops, reload begins at addr 0.
- LOADER_CHECKSUM_EN: 512 bytes of 0xA5 plus checksum byte 0x00 -> err=0, done=1. Checksum byte 0x01 -> err=1, done=1.
